// File: rtl/apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_slave
// Purpose  : APB3 completer that owns the board LEDs and samples the switches.
//            Switch edges are latched in a W1C status register that drives a level irq.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_slave #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [7:0]  LED_RESET   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PADDR,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic        PREADY,
   output logic [31:0] PRDATA,
   output logic        PSLVERR,
   output logic [7:0]  led,
   input  logic [7:0]  sw,
   output logic        irq
);

   localparam logic [31:0] C_ID = 32'h47504931;
   localparam logic [2:0]  C_WS = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        pready_q, pready_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pslverr_q, pslverr_d;
   logic [4:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [7:0]  wdata_q, wdata_d;

   logic [7:0]  led_q, led_d;
   logic [7:0]  status_q, status_d;
   logic [7:0]  ien_q, ien_d;
   logic        irq_q, irq_d;
   logic [7:0]  s1_q, s2_q, prev_q;

   logic        w_setup;
   logic [4:0]  w_addr;
   logic        w_write;
   logic [2:0]  w_idx;
   logic        w_err;
   logic [31:0] w_rdata;
   logic        w_commit;
   logic [7:0]  w_clr;
   logic [7:0]  w_edge;
   logic        w_unused;

   assign w_unused = ^{PADDR[31:5], PWDATA[31:8]};

   assign w_setup = PSEL & ~PENABLE;
   // With zero wait states the response is built during setup, before the capture registers load.
   assign w_addr  = (state_q == S_IDLE) ? PADDR[4:0] : addr_q;
   assign w_write = (state_q == S_IDLE) ? PWRITE     : write_q;
   assign w_idx   = w_addr[4:2];

   always_comb begin
      w_err = 1'b0;
      if (w_addr[1:0] != 2'b00)                            w_err = 1'b1;
      if (w_idx > 3'd4)                                    w_err = 1'b1;
      if (w_write && (w_idx == 3'd1 || w_idx == 3'd4))     w_err = 1'b1;
   end

   always_comb begin
      w_rdata = 32'h0;
      case (w_idx)
         3'd0:    w_rdata = {24'h0, led_q};
         3'd1:    w_rdata = {24'h0, s2_q};
         3'd2:    w_rdata = {24'h0, status_q};
         3'd3:    w_rdata = {24'h0, ien_q};
         3'd4:    w_rdata = C_ID;
         default: w_rdata = 32'h0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = 1'b0;
      prdata_d  = 32'h0;
      pslverr_d = 1'b0;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (w_setup) begin
               addr_d  = PADDR[4:0];
               write_d = PWRITE;
               wdata_d = PWDATA[7:0];
               if (C_WS == 3'd0) begin
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  pslverr_d = w_err;
                  prdata_d  = (w_err || w_write) ? 32'h0 : w_rdata;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = C_WS;
               end
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q <= 3'd1) begin
               // Counter reaching zero is registered together with PREADY.
               state_d   = S_RESP;
               cnt_d     = 3'd0;
               pready_d  = 1'b1;
               pslverr_d = w_err;
               prdata_d  = (w_err || w_write) ? 32'h0 : w_rdata;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign w_commit = (state_q == S_RESP) & PSEL & PENABLE & pready_q & write_q & ~pslverr_q;
   assign w_edge   = s2_q ^ prev_q;
   assign w_clr    = (w_commit && addr_q[4:2] == 3'd2) ? wdata_q : 8'h00;

   always_comb begin
      led_d    = led_q;
      ien_d    = ien_q;
      if (w_commit && addr_q[4:2] == 3'd0) led_d = wdata_q;
      if (w_commit && addr_q[4:2] == 3'd3) ien_d = wdata_q;
      status_d = (status_q & ~w_clr) | w_edge;
      irq_d    = |(status_q & ien_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         pready_q  <= 1'b0;
         prdata_q  <= 32'h0;
         pslverr_q <= 1'b0;
         addr_q    <= 5'h0;
         write_q   <= 1'b0;
         wdata_q   <= 8'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q    <= LED_RESET;
         status_q <= 8'h0;
         ien_q    <= 8'h0;
         irq_q    <= 1'b0;
         s1_q     <= 8'h0;
         s2_q     <= 8'h0;
         prev_q   <= 8'h0;
      end else begin
         led_q    <= led_d;
         status_q <= status_d;
         ien_q    <= ien_d;
         irq_q    <= irq_d;
         s1_q     <= sw;
         s2_q     <= s1_q;
         prev_q   <= s2_q;
      end
   end

   assign PREADY  = pready_q;
   assign PRDATA  = prdata_q;
   assign PSLVERR = pslverr_q;
   assign led     = led_q;
   assign irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_slave
// Purpose  : Directed self-checking bench for apb_gpio_slave (1 and 3 wait states).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PADDR, PWDATA;
   logic        PENABLE, PWRITE;
   logic        psel1, psel3;
   logic [7:0]  sw;
   logic        pready1, pslverr1, irq1, pready3, pslverr3, irq3;
   logic [31:0] prdata1, prdata3;
   logic [7:0]  led1, led3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_gpio_slave #(.WAIT_STATES(1), .LED_RESET(8'h00)) u_dut1 (
      .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(psel1), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready1), .PRDATA(prdata1),
      .PSLVERR(pslverr1), .led(led1), .sw(sw), .irq(irq1)
   );

   apb_gpio_slave #(.WAIT_STATES(3), .LED_RESET(8'h5A)) u_dut3 (
      .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(psel3), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready3), .PRDATA(prdata3),
      .PSLVERR(pslverr3), .led(led3), .sw(sw), .irq(irq3)
   );

   // Starts a setup phase at the current time (just after a rising edge) and returns
   // at the same offset after the completing edge. swc[8] requests a switch change at setup.
   task automatic xfer(input bit d3, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [8:0] swc, output logic [31:0] rd, output logic e, output int lat);
      bit done;
      done = 1'b0;
      rd = 32'h0; e = 1'b0; lat = 0;
      if (d3) psel3 = 1'b1; else psel1 = 1'b1;
      PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd;
      if (swc[8]) sw = swc[7:0];
      @(posedge clk); #1;
      PENABLE = 1'b1;
      while (!done && lat < 20) begin
         lat++;
         @(negedge clk);
         if ((d3 ? pready3 : pready1) === 1'b1) begin
            rd   = d3 ? prdata3 : prdata1;
            e    = d3 ? pslverr3 : pslverr1;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      psel1 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL xfer_timeout addr=%h: PREADY stayed low, required high within 20 cycles", a);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic e; int lat;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++; if (led1 !== 8'h00)  begin n_fail++; $display("FAIL reset_led: got %h expected 00", led1); end
      n_checks++; if (led3 !== 8'h5A)  begin n_fail++; $display("FAIL reset_led_param: got %h expected 5a", led3); end
      n_checks++; if (irq1 !== 1'b0)   begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq1); end
      n_checks++; if (pready1 !== 1'b0 || prdata1 !== 32'h0 || pslverr1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_apb: got ready=%b data=%h err=%b expected 0/0/0", pready1, prdata1, pslverr1);
      end
      xfer(1'b0, 32'h10, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (lat !== 2)              begin n_fail++; $display("FAIL id_latency: got %0d expected 2", lat); end
      n_checks++; if (rd !== 32'h47504931)    begin n_fail++; $display("FAIL id_read: got %h expected 47504931", rd); end
      n_checks++; if (e !== 1'b0)             begin n_fail++; $display("FAIL id_err: got %b expected 0", e); end
   endtask

   task automatic test_led();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b0, 32'h00, 1'b1, 32'h000000A5, 9'h0, rd, e, lat);
      n_checks++; if (led1 !== 8'hA5)      begin n_fail++; $display("FAIL led_write: got %h expected a5", led1); end
      xfer(1'b0, 32'h00, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h000000A5) begin n_fail++; $display("FAIL led_readback: got %h expected 000000a5", rd); end
      xfer(1'b0, 32'h00, 1'b1, 32'hFFFFFF3C, 9'h0, rd, e, lat);
      n_checks++; if (led1 !== 8'h3C)      begin n_fail++; $display("FAIL led_upper_ignored: got %h expected 3c", led1); end
      xfer(1'b0, 32'h00, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h0000003C) begin n_fail++; $display("FAIL led_readback2: got %h expected 0000003c", rd); end
   endtask

   task automatic test_switch_irq();
      logic [31:0] rd; logic e; int lat;
      sw = 8'h04;
      repeat (3) @(posedge clk);
      #1;
      xfer(1'b0, 32'h04, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL sw_read: got %h expected 00000004", rd); end
      xfer(1'b0, 32'h08, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL status_set: got %h expected 00000004", rd); end
      n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq1); end
      xfer(1'b0, 32'h0C, 1'b1, 32'h04, 9'h0, rd, e, lat);
      n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL irq_not_early: got %b expected 0", irq1); end
      @(posedge clk); #1;
      n_checks++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq1); end
      xfer(1'b0, 32'h08, 1'b1, 32'h04, 9'h0, rd, e, lat);
      n_checks++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL irq_hold_one_cycle: got %b expected 1", irq1); end
      @(posedge clk); #1;
      n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b expected 0", irq1); end
      xfer(1'b0, 32'h08, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h0)  begin n_fail++; $display("FAIL status_w1c: got %h expected 00000000", rd); end
   endtask

   task automatic test_race();
      logic [31:0] rd; logic e; int lat;
      sw = 8'h05;
      repeat (4) @(posedge clk);
      #1;
      xfer(1'b0, 32'h08, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL race_pre: got %h expected 00000001", rd); end
      // sw[0] falls at setup so its synced edge reaches STATUS on the W1C commit edge.
      xfer(1'b0, 32'h08, 1'b1, 32'h01, {1'b1, 8'h04}, rd, e, lat);
      xfer(1'b0, 32'h08, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL race_set_wins: got %h expected 00000001", rd); end
      xfer(1'b0, 32'h08, 1'b1, 32'h01, 9'h0, rd, e, lat);
      xfer(1'b0, 32'h08, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL race_clear_after: got %h expected 00000000", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b0, 32'h14, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_unmapped_read: got err=%b data=%h expected 1/0", e, rd); end
      xfer(1'b0, 32'h04, 1'b1, 32'hFF, 9'h0, rd, e, lat);
      n_checks++; if (e !== 1'b1)    begin n_fail++; $display("FAIL err_write_sw: got %b expected 1", e); end
      xfer(1'b0, 32'h10, 1'b1, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (e !== 1'b1)    begin n_fail++; $display("FAIL err_write_id: got %b expected 1", e); end
      xfer(1'b0, 32'h02, 1'b1, 32'h55, 9'h0, rd, e, lat);
      n_checks++; if (e !== 1'b1)    begin n_fail++; $display("FAIL err_misaligned_write: got %b expected 1", e); end
      n_checks++; if (led1 !== 8'h3C) begin n_fail++; $display("FAIL err_led_unchanged: got %h expected 3c", led1); end
      xfer(1'b0, 32'h0D, 1'b1, 32'h00, 9'h0, rd, e, lat);
      xfer(1'b0, 32'h0C, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h04 || e !== 1'b0) begin n_fail++; $display("FAIL err_ien_unchanged: got %h err=%b expected 00000004 err=0", rd, e); end
      xfer(1'b0, 32'h11, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned_read: got err=%b data=%h expected 1/0", e, rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b0, 32'h00, 1'b1, 32'h11, 9'h0, rd, e, lat);
      xfer(1'b0, 32'h00, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (rd !== 32'h11 || lat !== 2) begin n_fail++; $display("FAIL b2b_read: got %h lat=%0d expected 00000011 lat=2", rd, lat); end
   endtask

   task automatic test_wait_abort();
      logic [31:0] rd; logic e; int lat; bit seen;
      xfer(1'b1, 32'h10, 1'b0, 32'h0, 9'h0, rd, e, lat);
      n_checks++; if (lat !== 4 || rd !== 32'h47504931) begin n_fail++; $display("FAIL ws3_id: got lat=%0d data=%h expected lat=4 data=47504931", lat, rd); end
      psel3 = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1; PWDATA = 32'h77;
      @(posedge clk); #1 PENABLE = 1'b1;
      @(negedge clk);
      n_checks++; if (pready3 !== 1'b0 || prdata3 !== 32'h0 || pslverr3 !== 1'b0) begin
         n_fail++; $display("FAIL wait_outputs_low: got ready=%b data=%h err=%b expected 0/0/0", pready3, prdata3, pslverr3);
      end
      @(posedge clk); #1 psel3 = 1'b0; PENABLE = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (pready3 !== 1'b0) seen = 1'b1; end
      @(posedge clk); #1;
      n_checks++; if (seen)           begin n_fail++; $display("FAIL abort_no_pready: got PREADY high expected low"); end
      n_checks++; if (led3 !== 8'h5A) begin n_fail++; $display("FAIL abort_no_write: got %h expected 5a", led3); end
      // Raise irq on the WS=1 instance so the asynchronous reset has something to clear.
      sw = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (irq1 !== 1'b1)  begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq1); end
      psel3 = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1; PWDATA = 32'h33;
      @(posedge clk); #1 PENABLE = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (led1 !== 8'h00 || irq1 !== 1'b0 || pready1 !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_dut1: got led=%h irq=%b ready=%b expected 00/0/0", led1, irq1, pready1);
      end
      n_checks++; if (led3 !== 8'h5A || pready3 !== 1'b0 || prdata3 !== 32'h0) begin
         n_fail++; $display("FAIL async_reset_dut3: got led=%h ready=%b data=%h expected 5a/0/0", led3, pready3, prdata3);
      end
      @(posedge clk); #1 rst = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (pready3 !== 1'b0) seen = 1'b1; end
      @(posedge clk); #1;
      n_checks++; if (seen || led3 !== 8'h5A) begin n_fail++; $display("FAIL reset_cancels_xfer: got seen=%b led=%h expected 0/5a", seen, led3); end
   endtask

   initial begin
      rst = 1'b1; psel1 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 32'h0; PWDATA = 32'h0; sw = 8'h00;
      test_reset();
      test_led();
      test_switch_irq();
      test_race();
      test_errors();
      test_back_to_back();
      test_wait_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
